// File: rtl/cic_d_mc.sv
// Multichannel runtime-rate CIC decimator: time-interleaved channels share one
// integrator/comb datapath; output is shift-normalised, saturated and channel-tagged.
module cic_d_mc #(
    parameter int unsigned INP_DW    = 16,
    parameter int unsigned OUT_DW    = 16,
    parameter int unsigned RATE_DW   = 16,
    parameter int unsigned CIC_R_MAX = 64,
    parameter int unsigned CIC_R_DEF = 16,
    parameter int unsigned CIC_N     = 4,
    parameter int unsigned CIC_M     = 1,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CH_DW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INP_DW-1:0]  s_axis_in_tdata,
    input  logic [CH_DW-1:0]   s_axis_in_tuser,
    input  logic               s_axis_in_tvalid,
    input  logic [RATE_DW-1:0] s_axis_rate_tdata,
    input  logic               s_axis_rate_tvalid,
    output logic [OUT_DW-1:0]  m_axis_out_tdata,
    output logic [CH_DW-1:0]   m_axis_out_tuser,
    output logic               m_axis_out_tlast,
    output logic               m_axis_out_tvalid,
    output logic               sync_err
);

    localparam int unsigned W     = INP_DW + CIC_N * $clog2(CIC_R_MAX * CIC_M);
    localparam int unsigned SH_DW = $clog2(W + 1);
    localparam int unsigned PW    = RATE_DW + 8;

    // Integrator state and pipeline
    logic signed [W-1:0] int_q [CIC_N][NUM_CH];
    logic signed [W-1:0] int_d [CIC_N][NUM_CH];
    logic signed [W-1:0] ip_q [CIC_N];
    logic signed [W-1:0] ip_d [CIC_N];
    logic [CH_DW-1:0]    ip_ch_q [CIC_N];
    logic [CH_DW-1:0]    ip_ch_d [CIC_N];
    logic [CIC_N-1:0]    ip_vld_q, ip_vld_d;

    // Comb state and pipeline
    logic signed [W-1:0] cdly_q [CIC_N][NUM_CH][CIC_M];
    logic signed [W-1:0] cdly_d [CIC_N][NUM_CH][CIC_M];
    logic signed [W-1:0] cp_q [CIC_N];
    logic signed [W-1:0] cp_d [CIC_N];
    logic [CH_DW-1:0]    cp_ch_q [CIC_N];
    logic [CH_DW-1:0]    cp_ch_d [CIC_N];
    logic [SH_DW-1:0]    cp_sh_q [CIC_N];
    logic [SH_DW-1:0]    cp_sh_d [CIC_N];
    logic [CIC_N-1:0]    cp_vld_q, cp_vld_d;

    logic signed [W-1:0] cin_c [CIC_N];
    logic [CH_DW-1:0]    cin_ch_c [CIC_N];
    logic [SH_DW-1:0]    cin_sh_c [CIC_N];
    logic [CIC_N-1:0]    cin_vld_c;

    logic [CH_DW-1:0]    exp_ch_q, exp_ch_d;
    logic                sync_err_q, sync_err_d;
    logic [RATE_DW-1:0]  dec_cnt_q, dec_cnt_d;
    logic [RATE_DW-1:0]  cur_r_q, cur_r_d;
    logic [RATE_DW-1:0]  pend_r_q, pend_r_d;
    logic [OUT_DW-1:0]   out_data_q, out_data_d;
    logic [CH_DW-1:0]    out_ch_q, out_ch_d;
    logic                out_last_q, out_last_d;
    logic                out_vld_q, out_vld_d;

    logic signed [W-1:0] in_ext_c;
    logic signed [W-1:0] shifted_c;
    logic [SH_DW-1:0]    shift_c;
    logic                acc_c;
    logic                fwd_c;

    // Normalisation shift: CIC_N * ceil(log2(R * CIC_M))
    function automatic logic [SH_DW-1:0] calc_shift(input logic [RATE_DW-1:0] r);
        logic [PW-1:0] prod;
        int            lg;
        prod = PW'(r) * PW'(CIC_M);
        lg   = 0;
        for (int i = 0; i < int'(PW); i++) begin
            if ((PW'(1) << i) < prod) lg = i + 1;
        end
        return SH_DW'(int'(CIC_N) * lg);
    endfunction

    assign in_ext_c = {{(W - INP_DW){s_axis_in_tdata[INP_DW-1]}}, s_axis_in_tdata};
    assign shift_c  = calc_shift(cur_r_q);

    // Channel-order tracking and integrator cascade
    always_comb begin
        int_d      = int_q;
        ip_d       = ip_q;
        ip_ch_d    = ip_ch_q;
        ip_vld_d   = '0;
        exp_ch_d   = exp_ch_q;
        sync_err_d = 1'b0;
        acc_c      = 1'b0;
        if (s_axis_in_tvalid) begin
            if (s_axis_in_tuser == exp_ch_q) begin
                acc_c    = 1'b1;
                exp_ch_d = (exp_ch_q == CH_DW'(NUM_CH - 1)) ? '0 : exp_ch_q + CH_DW'(1);
            end else begin
                sync_err_d = 1'b1;
                exp_ch_d   = '0;
            end
        end
        ip_vld_d[0] = acc_c;
        if (acc_c) begin
            int_d[0][s_axis_in_tuser] = int_q[0][s_axis_in_tuser] + in_ext_c;
            ip_d[0]    = int_q[0][s_axis_in_tuser] + in_ext_c;
            ip_ch_d[0] = s_axis_in_tuser;
        end
        for (int k = 1; k < int'(CIC_N); k++) begin
            ip_vld_d[k] = ip_vld_q[k-1];
            if (ip_vld_q[k-1]) begin
                int_d[k][ip_ch_q[k-1]] = int_q[k][ip_ch_q[k-1]] + ip_q[k-1];
                ip_d[k]    = int_q[k][ip_ch_q[k-1]] + ip_q[k-1];
                ip_ch_d[k] = ip_ch_q[k-1];
            end
        end
    end

    // Decimation counter; pending rate is adopted only at a wrap
    always_comb begin
        dec_cnt_d = dec_cnt_q;
        cur_r_d   = cur_r_q;
        pend_r_d  = pend_r_q;
        fwd_c     = ip_vld_q[CIC_N-1] && (dec_cnt_q == cur_r_q - RATE_DW'(1));
        if (ip_vld_q[CIC_N-1] && (ip_ch_q[CIC_N-1] == CH_DW'(NUM_CH - 1))) begin
            if (fwd_c) begin
                dec_cnt_d = '0;
                cur_r_d   = pend_r_q;
            end else begin
                dec_cnt_d = dec_cnt_q + RATE_DW'(1);
            end
        end
        if (s_axis_rate_tvalid && (s_axis_rate_tdata != '0) &&
            (s_axis_rate_tdata <= RATE_DW'(CIC_R_MAX))) begin
            pend_r_d = s_axis_rate_tdata;
        end
    end

    // Comb stage inputs; the shift travels with the frame so a rate change never splits one
    always_comb begin
        cin_vld_c[0] = fwd_c;
        cin_c[0]     = ip_q[CIC_N-1];
        cin_ch_c[0]  = ip_ch_q[CIC_N-1];
        cin_sh_c[0]  = shift_c;
        for (int k = 1; k < int'(CIC_N); k++) begin
            cin_vld_c[k] = cp_vld_q[k-1];
            cin_c[k]     = cp_q[k-1];
            cin_ch_c[k]  = cp_ch_q[k-1];
            cin_sh_c[k]  = cp_sh_q[k-1];
        end
    end

    always_comb begin
        cdly_d   = cdly_q;
        cp_d     = cp_q;
        cp_ch_d  = cp_ch_q;
        cp_sh_d  = cp_sh_q;
        cp_vld_d = '0;
        for (int k = 0; k < int'(CIC_N); k++) begin
            cp_vld_d[k] = cin_vld_c[k];
            if (cin_vld_c[k]) begin
                cp_d[k]    = cin_c[k] - cdly_q[k][cin_ch_c[k]][CIC_M-1];
                cp_ch_d[k] = cin_ch_c[k];
                cp_sh_d[k] = cin_sh_c[k];
                cdly_d[k][cin_ch_c[k]][0] = cin_c[k];
                for (int m = 1; m < int'(CIC_M); m++) begin
                    cdly_d[k][cin_ch_c[k]][m] = cdly_q[k][cin_ch_c[k]][m-1];
                end
            end
        end
    end

    // Normalise and saturate
    always_comb begin
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        out_last_d = 1'b0;
        out_vld_d  = cp_vld_q[CIC_N-1];
        shifted_c  = cp_q[CIC_N-1] >>> cp_sh_q[CIC_N-1];
        if (cp_vld_q[CIC_N-1]) begin
            out_ch_d   = cp_ch_q[CIC_N-1];
            out_last_d = (cp_ch_q[CIC_N-1] == CH_DW'(NUM_CH - 1));
            if ((shifted_c[W-1:OUT_DW-1] == '0) || (shifted_c[W-1:OUT_DW-1] == '1)) begin
                out_data_d = shifted_c[OUT_DW-1:0];
            end else if (shifted_c[W-1]) begin
                out_data_d = {1'b1, {(OUT_DW - 1){1'b0}}};
            end else begin
                out_data_d = {1'b0, {(OUT_DW - 1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_q      <= '{default: '0};
            ip_q       <= '{default: '0};
            ip_ch_q    <= '{default: '0};
            ip_vld_q   <= '0;
            cdly_q     <= '{default: '0};
            cp_q       <= '{default: '0};
            cp_ch_q    <= '{default: '0};
            cp_sh_q    <= '{default: '0};
            cp_vld_q   <= '0;
            exp_ch_q   <= '0;
            sync_err_q <= 1'b0;
            dec_cnt_q  <= '0;
            cur_r_q    <= RATE_DW'(CIC_R_DEF);
            pend_r_q   <= RATE_DW'(CIC_R_DEF);
            out_data_q <= '0;
            out_ch_q   <= '0;
            out_last_q <= 1'b0;
            out_vld_q  <= 1'b0;
        end else begin
            int_q      <= int_d;
            ip_q       <= ip_d;
            ip_ch_q    <= ip_ch_d;
            ip_vld_q   <= ip_vld_d;
            cdly_q     <= cdly_d;
            cp_q       <= cp_d;
            cp_ch_q    <= cp_ch_d;
            cp_sh_q    <= cp_sh_d;
            cp_vld_q   <= cp_vld_d;
            exp_ch_q   <= exp_ch_d;
            sync_err_q <= sync_err_d;
            dec_cnt_q  <= dec_cnt_d;
            cur_r_q    <= cur_r_d;
            pend_r_q   <= pend_r_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            out_last_q <= out_last_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign m_axis_out_tdata  = out_data_q;
    assign m_axis_out_tuser  = out_ch_q;
    assign m_axis_out_tlast  = out_last_q;
    assign m_axis_out_tvalid = out_vld_q;
    assign sync_err          = sync_err_q;

endmodule
